// File: rtl/jk_excite_driver.sv
// Drives J/K of an external JK flip-flop so its Q follows an 8-bit target sequence (LSB first),
// then checks the flip-flop's Q two edges after each J/K value was registered.
module jk_excite_driver #(
  parameter bit TOGGLE_PREF = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       q_fb,
  output logic       J,
  output logic       K,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [3:0] err_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic [DW-1:0] din_q;
  logic [IW-1:0] idx_q;
  logic          exp_q;
  logic          drain_q;
  logic          s1_vld_q;
  logic          s1_bit_q;
  logic          s2_vld_q;
  logic          s2_bit_q;
  logic          word_ok_q;
  logic          j_q;
  logic          k_q;
  logic          done_q;
  logic          pass_q;
  logic          mm_q;
  logic [CW-1:0] err_q;

  logic tgt_c;
  logic j_c;
  logic k_c;
  logic fail_c;

  // Excitation for the current transition and the check of the oldest in-flight bit
  always_comb begin
    tgt_c = din_q[idx_q];
    j_c   = 1'b0;
    k_c   = 1'b0;
    if (TOGGLE_PREF) begin
      j_c = exp_q ^ tgt_c;
      k_c = exp_q ^ tgt_c;
    end else begin
      j_c = !exp_q && tgt_c;
      k_c = exp_q && !tgt_c;
    end
    fail_c = s2_vld_q && (q_fb != s2_bit_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      din_q     <= '0;
      idx_q     <= '0;
      exp_q     <= 1'b0;
      drain_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_bit_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_bit_q  <= 1'b0;
      word_ok_q <= 1'b0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mm_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      mm_q     <= fail_c;
      s1_vld_q <= 1'b0;
      s2_vld_q <= s1_vld_q;
      s2_bit_q <= s1_bit_q;
      if (fail_c) begin
        word_ok_q <= 1'b0;
        if (err_q != {CW{1'b1}}) begin
          err_q <= err_q + CW'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            din_q     <= din;
            idx_q     <= '0;
            exp_q     <= q_fb;
            word_ok_q <= 1'b1;
            state_q   <= DRIVE;
          end
        end
        DRIVE: begin
          j_q      <= j_c;
          k_q      <= k_c;
          exp_q    <= tgt_c;
          idx_q    <= idx_q + IW'(1);
          s1_vld_q <= 1'b1;
          s1_bit_q <= tgt_c;
          if (idx_q == IW'(DW - 1)) begin
            drain_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Two edges let the checks of the last two bits complete
          j_q <= 1'b0;
          k_q <= 1'b0;
          if (drain_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            pass_q  <= word_ok_q && !fail_c;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign J         = j_q;
  assign K         = k_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mm_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver: two instances (set/reset and toggle preferred),
// each driving its own ideal JK flip-flop model.
module tb_jk_excite_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       tie0;

  logic       rdy0, j0, k0, busy0, done0, pass0, mm0;
  logic [3:0] err0;
  logic       rdy1, j1, k1, busy1, done1, pass1, mm1;
  logic [3:0] err1;
  logic       qm0, qm1;
  logic       qfb0, qfb1;

  assign qfb0 = tie0 ? 1'b0 : qm0;
  assign qfb1 = tie0 ? 1'b0 : qm1;

  jk_excite_driver #(.TOGGLE_PREF(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .q_fb(qfb0), .J(j0), .K(k0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch(mm0), .err_cnt(err0)
  );

  jk_excite_driver #(.TOGGLE_PREF(1'b1)) u1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .q_fb(qfb1), .J(j1), .K(k1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch(mm1), .err_cnt(err1)
  );

  // Ideal JK flip-flops clocked by the same edge
  always @(posedge clk) begin
    if (reset) begin
      qm0 <= 1'b0;
      qm1 <= 1'b0;
    end else begin
      case ({j0, k0})
        2'b01:   qm0 <= 1'b0;
        2'b10:   qm0 <= 1'b1;
        2'b11:   qm0 <= ~qm0;
        default: qm0 <= qm0;
      endcase
      case ({j1, k1})
        2'b01:   qm1 <= 1'b0;
        2'b10:   qm1 <= 1'b1;
        2'b11:   qm1 <= ~qm1;
        default: qm1 <= qm1;
      endcase
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] jk0_h [10];
  logic [1:0] jk1_h [10];
  int         mm_seen;
  int         done_tick;
  logic       pass_at_done;
  logic [3:0] err_at_done;
  logic       busy_after;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a word, take the accept edge, then observe the 10 following edges
  task automatic run_word(input logic [7:0] d, input bit hold, input logic [7:0] d_next);
    din       = d;
    din_valid = 1'b1;
    chk("ready_before_accept", 32'(rdy0), 32'd1);
    tick;
    busy_after = busy0;
    if (hold) din = d_next;
    else      din_valid = 1'b0;
    mm_seen      = 0;
    done_tick    = -1;
    pass_at_done = 1'b0;
    err_at_done  = '0;
    for (int t = 1; t <= 10; t++) begin
      tick;
      jk0_h[t-1] = {j0, k0};
      jk1_h[t-1] = {j1, k1};
      if (mm0) mm_seen++;
      if (done0 && done_tick < 0) begin
        done_tick    = t;
        pass_at_done = pass0;
        err_at_done  = err0;
      end
    end
  endtask

  logic [1:0] exp_a5_0 [10];
  logic [1:0] exp_a5_1 [10];
  logic [1:0] exp_0f   [10];
  logic [1:0] exp_f0   [10];
  int         done_cnt;

  initial begin
    exp_a5_0 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_a5_1 = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    exp_0f   = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_f0   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    // Reset held two edges with din_valid high
    reset     = 1'b1;
    din       = 8'h3C;
    din_valid = 1'b1;
    tie0      = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_j", 32'(j0), 32'd0);
    chk("rst_k", 32'(k0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    tick;
    chk("rst2_ready", 32'(rdy0), 32'd0);
    chk("rst2_busy", 32'(busy0), 32'd0);
    chk("rst2_done", 32'(done0), 32'd0);
    reset     = 1'b0;
    din_valid = 1'b0;
    tick;
    chk("post_rst_ready", 32'(rdy0), 32'd1);
    chk("post_rst_busy", 32'(busy0), 32'd0);

    // 8'hA5 into ideal flip-flops, both excitation preferences
    run_word(8'hA5, 1'b0, 8'h00);
    chk("a5_busy", 32'(busy_after), 32'd1);
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("a5_jk_p0_%0d", t), 32'(jk0_h[t]), 32'(exp_a5_0[t]));
      chk($sformatf("a5_jk_p1_%0d", t), 32'(jk1_h[t]), 32'(exp_a5_1[t]));
    end
    chk("a5_done_tick", 32'(done_tick), 32'd10);
    chk("a5_pass", 32'(pass_at_done), 32'd1);
    chk("a5_err", 32'(err_at_done), 32'd0);
    chk("a5_mm", 32'(mm_seen), 32'd0);
    chk("a5_done_p1", 32'(done1), 32'd1);
    chk("a5_pass_p1", 32'(pass1), 32'd1);
    chk("a5_ready_done", 32'(rdy0), 32'd1);
    tick;
    chk("a5_done_pulse", 32'(done0), 32'd0);

    // Q stuck at 0 with all-ones target: every check fails, counter saturates
    tie0 = 1'b1;
    run_word(8'hFF, 1'b0, 8'h00);
    chk("ff1_mm", 32'(mm_seen), 32'd8);
    chk("ff1_done_tick", 32'(done_tick), 32'd10);
    chk("ff1_pass", 32'(pass_at_done), 32'd0);
    chk("ff1_err", 32'(err_at_done), 32'd8);
    run_word(8'hFF, 1'b0, 8'h00);
    chk("ff2_mm", 32'(mm_seen), 32'd8);
    chk("ff2_pass", 32'(pass_at_done), 32'd0);
    chk("ff2_err", 32'(err_at_done), 32'd15);
    tie0 = 1'b0;
    tick;
    chk("ff_err_hold", 32'(err0), 32'd15);

    // Reset after DRIVE bit 4 aborts the word
    din       = 8'hA5;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    repeat (5) tick;
    chk("abort_busy_pre", 32'(busy0), 32'd1);
    reset = 1'b1;
    tick;
    chk("abort_j", 32'(j0), 32'd0);
    chk("abort_k", 32'(k0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_err", 32'(err0), 32'd0);
    chk("abort_ready_in_rst", 32'(rdy0), 32'd0);
    reset = 1'b0;
    tick;
    chk("abort_ready", 32'(rdy0), 32'd1);
    done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      if (done0) done_cnt++;
      tick;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Back-to-back words with din_valid held high
    run_word(8'h0F, 1'b1, 8'hF0);
    chk("b2b1_busy", 32'(busy_after), 32'd1);
    for (int t = 0; t < 10; t++)
      chk($sformatf("b2b1_jk_%0d", t), 32'(jk0_h[t]), 32'(exp_0f[t]));
    chk("b2b1_done_tick", 32'(done_tick), 32'd10);
    chk("b2b1_pass", 32'(pass_at_done), 32'd1);
    run_word(8'hF0, 1'b0, 8'h00);
    chk("b2b2_busy", 32'(busy_after), 32'd1);
    for (int t = 0; t < 10; t++)
      chk($sformatf("b2b2_jk_%0d", t), 32'(jk0_h[t]), 32'(exp_f0[t]));
    chk("b2b2_done_tick", 32'(done_tick), 32'd10);
    chk("b2b2_pass", 32'(pass_at_done), 32'd1);
    chk("b2b2_err", 32'(err_at_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 Parameter TOGGLE_PREF, default 0, selects the excitation don't-care choice: 0 = set/reset preferred, 1 = toggle preferred.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 din  input  8  target Q sequence, applied LSB first.
REQ-005 din_valid  input  1  din is offered.
REQ-006 din_ready  output  1  block can accept a word.
REQ-007 q_fb  input  1  Q output of the driven external JK flip-flop.
REQ-008 J  output  1  registered J drive.
REQ-009 K  output  1  registered K drive.
REQ-010 busy  output  1  a word is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of each word.
REQ-012 pass  output  1  valid with done; 1 = no mismatch occurred in that word.
REQ-013 mismatch  output  1  one-cycle pulse per failed bit check.
REQ-014 err_cnt  output  4  cumulative mismatch count, saturating.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRIVE and DRAIN; din_ready SHALL equal (state==IDLE && !reset); busy SHALL equal (state!=IDLE).
REQ-016 On the accept edge (din_valid && din_ready), the block SHALL latch din, set bit index 0, set exp_q <= q_fb, and enter DRIVE.
REQ-017 In DRIVE, each edge SHALL register J/K = excite(exp_q, din[idx]), set exp_q <= din[idx] and increment idx; DRIVE SHALL last exactly 8 edges (bits 0..7).
REQ-018 With TOGGLE_PREF=0, excite SHALL be: 0->0 J0K0; 0->1 J1K0; 1->0 J0K1; 1->1 J0K0.
REQ-019 With TOGGLE_PREF=1, excite SHALL be: 0->1 and 1->0 J1K1; 0->0 and 1->1 J0K0.
REQ-020 The block SHALL carry the target bit of each DRIVE edge through a 2-stage check pipeline with valid bits, and SHALL compare q_fb against that bit two edges after the J/K value was registered.
REQ-021 On a failed check, mismatch SHALL pulse for one cycle, err_cnt SHALL increment and saturate at 15, and the word's pass flag SHALL clear.
REQ-022 After the 8th DRIVE edge the block SHALL enter DRAIN for 2 edges: J=K=0 registered on the first DRAIN edge, with checks for bits 6 and 7 completing during DRAIN.
REQ-023 On the second DRAIN edge the block SHALL return to IDLE, assert done=1 for one cycle, and present pass; done SHALL therefore be high in the cycle following the 10th edge after the accept edge.
REQ-024 din_valid SHALL be ignored outside IDLE, and din SHALL NOT be re-sampled mid-word.
REQ-025 Back-to-back words SHALL be supported: din_ready is high in the done cycle, so the next word is accepted on that cycle's edge.
REQ-026 err_cnt SHALL NOT clear on a new word; only reset clears it.

Reset
REQ-027 While reset is high on an edge, the block SHALL go to IDLE with J=0, K=0, done=0, pass=0, mismatch=0 and err_cnt=0, and SHALL clear both check-pipeline valid bits and idx.
REQ-028 Reset SHALL take priority over accept and over a check in the same edge, and a word aborted by reset SHALL produce no done.

Verification
REQ-029 Reset held 2 cycles with din_valid=1 -> din_ready=0, J=K=0, err_cnt=0, no word accepted; din_ready=1 in the first cycle after release.
REQ-030 Ideal JK model, q=0, TOGGLE_PREF=0, din=8'hA5 -> J/K over 8 cycles: 10,01,10,01,00,10,01,10; then 00; done=1 and pass=1 exactly 10 edges after accept; err_cnt=0.
REQ-031 Same stimulus with TOGGLE_PREF=1 -> J/K: 11,11,11,11,00,11,11,11; done with pass=1.
REQ-032 q_fb tied 0, din=8'hFF -> 8 mismatch pulses, err_cnt=8, pass=0; a second identical word -> err_cnt=15 (saturated), pass=0.
REQ-033 Reset asserted after DRIVE bit 4 -> next cycle J=K=0, busy=0, err_cnt=0; no done pulse; din_ready=1 after release.
REQ-034 din_valid held high with words 8'h0F then 8'hF0 -> second word accepted on the done-cycle edge; J/K for its bit 0 appear one edge later; both words report pass=1.
